// File: rtl/pc_sequencer.sv
// Fetch program counter: sequential step, stall, branch/jump redirect,
// and call/return through a small circular return-address stack.
module pc_sequencer #(
    parameter int unsigned     PC_W      = 32,
    parameter int unsigned     STEP      = 1,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp,
    input  logic            call,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            ret,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_ovf,
    output logic            ras_unf
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  rasMem [RAS_DEPTH];
    logic [PTR_W-1:0] topPtr;
    logic [PTR_W-1:0] nextPtr;
    logic [CNT_W-1:0] rasCount;
    logic [PC_W-1:0]  seqPc;
    logic             pushEn;
    logic             popEn;

    assign seqPc     = pc + PC_W'(STEP);
    assign nextPtr   = topPtr + PTR_W'(1);
    assign ras_empty = (rasCount == '0);
    assign ras_full  = (rasCount == CNT_MAX);

    // Priority chain; a losing request has no side effect on the stack.
    always_comb begin
        pushEn  = 1'b0;
        popEn   = 1'b0;
        pc_next = seqPc;
        if (reset) begin
            pc_next = RESET_PC;
        end else if (br_taken) begin
            pc_next = br_target;
        end else if (stall) begin
            pc_next = pc;
        end else if (ret) begin
            popEn = 1'b1;
            if (!ras_empty) begin
                pc_next = rasMem[topPtr];
            end
        end else if (call) begin
            pushEn  = 1'b1;
            pc_next = jmp_target;
        end else if (jmp) begin
            pc_next = jmp_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            topPtr   <= '0;
            rasCount <= '0;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
        end else begin
            pc <= pc_next;
            if (pushEn) begin
                // When full, advancing the pointer lands on the oldest entry.
                topPtr <= nextPtr;
                if (ras_full) begin
                    ras_ovf <= 1'b1;
                end else begin
                    rasCount <= rasCount + CNT_W'(1);
                end
            end
            if (popEn) begin
                if (ras_empty) begin
                    ras_unf <= 1'b1;
                end else begin
                    topPtr   <= topPtr - PTR_W'(1);
                    rasCount <= rasCount - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && pushEn) begin
            rasMem[nextPtr] <= seqPc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: reset, stall, redirects,
// call/return nesting, RAS overflow/underflow, priority and wrap-around.
module tb_pc_sequencer;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] brT;
        logic        jmp;
        logic        call;
        logic [31:0] jT;
        logic        ret;
        logic [31:0] expPc;
        logic        expEmpty;
        logic        expFull;
        logic        expOvf;
        logic        expUnf;
    } vecT;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic        call;
    logic [31:0] jmp_target;
    logic        ret;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_unf;

    int errors = 0;
    int checks = 0;
    vecT vecs[$];

    pc_sequencer #(
        .PC_W(32),
        .STEP(1),
        .RESET_PC(32'h0),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .br_taken(br_taken),
        .br_target(br_target),
        .jmp(jmp),
        .call(call),
        .jmp_target(jmp_target),
        .ret(ret),
        .pc(pc),
        .pc_next(pc_next),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .ras_ovf(ras_ovf),
        .ras_unf(ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vecT mk(input logic r, input logic s, input logic b,
                               input logic [31:0] bt, input logic j,
                               input logic c, input logic [31:0] jt,
                               input logic rt, input logic [31:0] ep,
                               input logic e, input logic f,
                               input logic o, input logic u);
        vecT v;
        v.rst = r;   v.stall = s; v.br = b;  v.brT = bt;
        v.jmp = j;   v.call = c;  v.jT = jt; v.ret = rt;
        v.expPc = ep;
        v.expEmpty = e; v.expFull = f; v.expOvf = o; v.expUnf = u;
        return v;
    endfunction

    task automatic add(input logic r, input logic s, input logic b,
                       input logic [31:0] bt, input logic j, input logic c,
                       input logic [31:0] jt, input logic rt,
                       input logic [31:0] ep, input logic e, input logic f,
                       input logic o, input logic u);
        vecs.push_back(mk(r, s, b, bt, j, c, jt, rt, ep, e, f, o, u));
    endtask

    task automatic apply(input vecT v, input string tag);
        @(negedge clk);
        reset      = v.rst;
        stall      = v.stall;
        br_taken   = v.br;
        br_target  = v.brT;
        jmp        = v.jmp;
        call       = v.call;
        jmp_target = v.jT;
        ret        = v.ret;
        #1;
        check({tag, " pc_next"}, pc_next, v.expPc);
        @(posedge clk);
        #1;
        check({tag, " pc"}, pc, v.expPc);
        check({tag, " empty"}, 32'(ras_empty), 32'(v.expEmpty));
        check({tag, " full"}, 32'(ras_full), 32'(v.expFull));
        check({tag, " ovf"}, 32'(ras_ovf), 32'(v.expOvf));
        check({tag, " unf"}, 32'(ras_unf), 32'(v.expUnf));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        jmp = 1'b0; call = 1'b0; jmp_target = '0; ret = 1'b0;

        //  rst st br brT       jmp cl jT        ret expPc     e f o u
        // reset, idle count, reset mid-run
        add(1, 0, 0, 0,        0, 0, 0,        0, 32'h0,     1, 0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 0,        0, 32'h1,     1, 0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 0,        0, 32'h2,     1, 0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 0,        0, 32'h3,     1, 0, 0, 0);
        add(1, 0, 0, 0,        0, 0, 0,        0, 32'h0,     1, 0, 0, 0);
        // stall hold, stall+branch, stall suppresses call
        add(0, 0, 0, 0,        1, 0, 32'h5,    0, 32'h5,     1, 0, 0, 0);
        add(0, 1, 0, 0,        0, 0, 0,        0, 32'h5,     1, 0, 0, 0);
        add(0, 1, 0, 0,        0, 0, 0,        0, 32'h5,     1, 0, 0, 0);
        add(0, 1, 1, 32'h40,   0, 0, 0,        0, 32'h40,    1, 0, 0, 0);
        add(0, 1, 0, 0,        0, 1, 32'h99,   0, 32'h40,    1, 0, 0, 0);
        // nested call/ret
        add(0, 0, 0, 0,        1, 0, 32'h10,   0, 32'h10,    1, 0, 0, 0);
        add(0, 0, 0, 0,        0, 1, 32'h80,   0, 32'h80,    0, 0, 0, 0);
        add(0, 0, 0, 0,        1, 0, 32'h81,   0, 32'h81,    0, 0, 0, 0);
        add(0, 0, 0, 0,        0, 1, 32'hC0,   0, 32'hC0,    0, 0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 0,        1, 32'h82,    0, 0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 0,        1, 32'h11,    1, 0, 0, 0);
        // five calls into a 4-deep RAS, then five rets
        add(0, 0, 0, 0,        0, 1, 32'h100,  0, 32'h100,   0, 0, 0, 0);
        add(0, 0, 0, 0,        0, 1, 32'h200,  0, 32'h200,   0, 0, 0, 0);
        add(0, 0, 0, 0,        0, 1, 32'h300,  0, 32'h300,   0, 0, 0, 0);
        add(0, 0, 0, 0,        0, 1, 32'h400,  0, 32'h400,   0, 1, 0, 0);
        add(0, 0, 0, 0,        0, 1, 32'h500,  0, 32'h500,   0, 1, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0,        1, 32'h401,   0, 0, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0,        1, 32'h301,   0, 0, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0,        1, 32'h201,   0, 0, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0,        1, 32'h101,   1, 0, 1, 0);
        add(0, 0, 0, 0,        0, 0, 0,        1, 32'h102,   1, 0, 1, 1);
        // priority: branch beats call/ret, ret beats call, call beats jmp
        add(0, 0, 1, 32'h200,  0, 1, 32'h700,  0, 32'h200,   1, 0, 1, 1);
        add(0, 0, 0, 0,        0, 1, 32'h300,  0, 32'h300,   0, 0, 1, 1);
        add(0, 0, 1, 32'h50,   0, 0, 0,        1, 32'h50,    0, 0, 1, 1);
        add(0, 0, 0, 0,        0, 1, 32'h900,  1, 32'h201,   1, 0, 1, 1);
        add(0, 0, 0, 0,        1, 1, 32'h600,  0, 32'h600,   0, 0, 1, 1);
        add(0, 0, 0, 0,        0, 0, 0,        1, 32'h202,   1, 0, 1, 1);
        // wrap-around, then reset overriding everything
        add(0, 0, 0, 0,        1, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1, 0, 1, 1);
        add(0, 0, 0, 0,        0, 0, 0,        0, 32'h0,     1, 0, 1, 1);
        add(1, 1, 1, 32'h77,   1, 1, 32'h88,   1, 32'h0,     1, 0, 0, 0);
        add(0, 0, 0, 0,        0, 0, 0,        0, 32'h1,     1, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // stalled ret over several cycles must not pop the stack
        apply(mk(0, 0, 0, 0, 0, 1, 32'h20, 0, 32'h20, 0, 0, 0, 0), "h0");
        for (int k = 0; k < 3; k++) begin
            apply(mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h20, 0, 0, 0, 0),
                  $sformatf("h%0d", k + 1));
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h2, 1, 0, 0, 0), "h4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
